pif_led_arbiter: RTL and testbench

Shares the board's single bicolour status LED between four requesters. A fixed-priority arbiter picks the owner. A tick-driven pattern engine then renders that owner's pattern (solid, blink, flash-count or red/green alternate) on the active-low red/green pins. It sits beside the free-running flasher. It is driven from the on-chip oscillator clock, and it replaces the flasher's hard-wired breathing sequence whenever firmware or status logic needs to signal something specific.

---
 rtl/pif_led_arbiter.sv | 127 ++++++++++++
 tb/tb_pif_led_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pif_led_arbiter.sv
// Shared bicolour status LED: fixed-priority owner selection plus a tick-driven
// pattern engine that renders the owner's latched pattern on active-low pins.
module pif_led_arbiter #(
  parameter int TICK_DIV     = 177333,
  parameter int PERIOD_TICKS = 150,
  parameter int FLASH_TICKS  = 8
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic [3:0]  Req,
  input  logic [7:0]  Mode,
  input  logic [3:0]  Colour,
  input  logic [11:0] Count,
  output logic [3:0]  Grant,
  output logic        Busy,
  output logic        Tick,
  output logic        red,
  output logic        green
);
  localparam int NUM_LANES = 4;
  localparam int DIV_W     = $clog2(TICK_DIV);
  localparam int PH_W      = $clog2(PERIOD_TICKS);

  typedef enum logic [1:0] {M_SOLID, M_BLINK, M_FLASH, M_ALT} mode_e;
  typedef struct packed {
    logic [1:0] mode;
    logic       colour;
    logic [2:0] count;
  } pat_t;

  logic [DIV_W-1:0]           div_cnt;
  logic [PH_W-1:0]            phase;
  pat_t                       pat;
  pat_t [NUM_LANES-1:0]       lane_pat;
  pat_t                       pat_nxt;
  logic [NUM_LANES-1:0]       grant_nxt;
  logic                       on, first_half, led_red, led_grn;
  logic [2:0]                 flash_n;
  int                         slot;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_pat[i] = {Mode[2*i +: 2], Colour[i], Count[3*i +: 3]};
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      div_cnt <= DIV_W'(TICK_DIV - 1);
      Tick    <= 1'b0;
    end else begin
      Tick    <= (div_cnt == '0);
      div_cnt <= (div_cnt == '0) ? DIV_W'(TICK_DIV - 1) : div_cnt - 1'b1;
    end
  end

  // Every arbitration rule reduces to "highest Req set wins"; the hold case
  // falls out because an unchallenged owner is itself the highest request.
  always_comb begin
    grant_nxt = '0;
    pat_nxt   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (Req[i]) begin
        grant_nxt = NUM_LANES'(1) << i;
        pat_nxt   = lane_pat[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Grant <= '0;
      phase <= '0;
      pat   <= '0;
    end else if (Tick) begin
      if (grant_nxt != Grant) begin
        Grant <= grant_nxt;
        phase <= '0;
        pat   <= pat_nxt;
      end else if (phase == PH_W'(PERIOD_TICKS - 1)) begin
        phase <= '0;
        pat   <= pat_nxt;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  assign Busy = |Grant;

  always_comb begin
    on         = 1'b0;
    led_red    = 1'b1;
    led_grn    = 1'b1;
    flash_n    = (pat.count == 3'd0) ? 3'd1 : pat.count;
    slot       = int'(phase) / FLASH_TICKS;
    first_half = int'(phase) < PERIOD_TICKS / 2;
    case (mode_e'(pat.mode))
      M_SOLID: on = 1'b1;
      M_BLINK: on = first_half;
      M_FLASH: on = (slot % 2 == 0) && (slot < 2 * int'(flash_n));
      default: on = 1'b0;
    endcase
    if (mode_e'(pat.mode) == M_ALT) begin
      led_red = !first_half;
      led_grn = first_half;
    end else if (pat.colour) begin
      led_grn = !on;
    end else begin
      led_red = !on;
    end
    if (Grant == '0) begin
      led_red = 1'b1;
      led_grn = 1'b1;
    end
  end

  // Final guard: a both-on request collapses to both-off.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      red   <= 1'b1;
      green <= 1'b1;
    end else begin
      red   <= led_red | ~led_grn;
      green <= led_grn | ~led_red;
    end
  end

endmodule

// File: tb/tb_pif_led_arbiter.sv
// Bench for pif_led_arbiter: a spec-level reference model pushes expected LED
// pins into a scoreboard queue; grant/tick are compared cycle by cycle.
module tb_pif_led_arbiter;
  localparam int TDIV   = 4;
  localparam int PERIOD = 16;
  localparam int FLASH  = 1;

  logic        Clk = 1'b0;
  logic        RstN;
  logic [3:0]  Req;
  logic [7:0]  Mode;
  logic [3:0]  Colour;
  logic [11:0] Count;
  logic [3:0]  Grant;
  logic        Busy, Tick, red, green;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] led_q[$];

  // reference model state
  int         m_cyc;
  logic       m_tick;
  logic [3:0] m_grant;
  int         m_phase;
  int         m_md;
  logic       m_col;
  int         m_cn;

  pif_led_arbiter #(.TICK_DIV(TDIV), .PERIOD_TICKS(PERIOD), .FLASH_TICKS(FLASH)) dut (
    .Clk(Clk), .RstN(RstN), .Req(Req), .Mode(Mode), .Colour(Colour), .Count(Count),
    .Grant(Grant), .Busy(Busy), .Tick(Tick), .red(red), .green(green)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] highest(logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return 4'(1 << i);
    return 4'b0;
  endfunction

  // {red, green} expected for a given owner, phase and latched pattern
  function automatic logic [1:0] exp_led(logic [3:0] g, int ph, int md, logic col, int cn);
    logic on;
    int   n;
    if (g == 4'b0) return 2'b11;
    on = 1'b0;
    case (md)
      0: on = 1'b1;
      1: on = ph < PERIOD / 2;
      2: begin
        n = (cn == 0) ? 1 : cn;
        for (int k = 0; k < n; k++)
          if (ph >= 2 * k * FLASH && ph < 2 * k * FLASH + FLASH) on = 1'b1;
      end
      default: return (ph < PERIOD / 2) ? 2'b01 : 2'b10;
    endcase
    if (!on) return 2'b11;
    return col ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_tick = 1'b0; m_grant = 4'b0; m_phase = 0;
    m_md = 0; m_col = 1'b0; m_cn = 0;
  endtask

  task automatic latch_fields(logic [3:0] g);
    m_md = 0; m_col = 1'b0; m_cn = 0;
    for (int i = 0; i < 4; i++)
      if (g[i]) begin
        m_md = int'(Mode[2*i +: 2]); m_col = Colour[i]; m_cn = int'(Count[3*i +: 3]);
      end
  endtask

  // one rising edge worth of spec behaviour, using the inputs held across it
  task automatic model_edge();
    logic [3:0] ng;
    m_cyc++;
    if (m_tick) begin
      ng = highest(Req);
      if (ng != m_grant) begin
        m_grant = ng; m_phase = 0; latch_fields(ng);
      end else if (m_phase == PERIOD - 1) begin
        m_phase = 0; latch_fields(m_grant);
      end else begin
        m_phase++;
      end
    end
    m_tick = (m_cyc % TDIV == 0);
  endtask

  task automatic step();
    logic [1:0] e;
    @(negedge Clk);
    if (RstN) model_edge();
    chk("tick", Tick, m_tick);
    chk("grant", Grant, m_grant);
    chk("busy", Busy, |m_grant);
    chk("sb_depth", led_q.size(), 1);
    if (led_q.size() > 0) begin
      e = led_q.pop_front();
      chk("led", {red, green}, e);
    end
    chk("led_not_both_on", red | green, 1);
    led_q.push_back(exp_led(m_grant, m_phase, m_md, m_col, m_cn));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wait_phase(int p);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (m_phase == p && !m_tick) begin found = 1'b1; break; end
    end
    chk("wait_phase", found, 1);
  endtask

  initial begin
    int n;
    RstN = 1'b0; Req = '0; Mode = '0; Colour = '0; Count = '0;
    model_reset();
    led_q.push_back(2'b11);

    // 1: reset values, then prescaler cadence
    run(3);
    RstN = 1'b1;
    n = 0;
    do begin step(); n++; end while (!Tick && n < 10);
    chk("first_tick_cycles", n, TDIV);
    run(12);

    // 2: solid red on requester 0
    Req = 4'b0001; Mode = 8'h00; Colour = 4'b0000;
    run(3 * PERIOD * TDIV + 16);

    // 3: blink green (mode change lands at the next wrap)
    Mode[1:0] = 2'd1; Colour[0] = 1'b1;
    run(2 * PERIOD * TDIV + 40);

    // 4: flash-count 3, then 0 changed mid-period
    Mode[1:0] = 2'd2; Count[2:0] = 3'd3;
    run(2 * PERIOD * TDIV);
    wait_phase(1);
    Count[2:0] = 3'd0;
    run(2 * PERIOD * TDIV);

    // 5: preemption by requester 3 (solid green) at phase 5, then release
    Mode[1:0] = 2'd1; Colour[0] = 1'b1;
    run(PERIOD * TDIV + 8);
    wait_phase(5);
    Req = 4'b1001; Mode[7:6] = 2'd0; Colour[3] = 1'b1;
    run(PERIOD * TDIV + 12);
    Req = 4'b0001;
    run(PERIOD * TDIV + 12);

    // alternate mode, and drop to idle
    Mode[1:0] = 2'd3;
    run(2 * PERIOD * TDIV);
    Req = 4'b0000;
    run(3 * TDIV);

    // 6: async reset mid-flash, then cold-start replay of solid red
    Req = 4'b0001; Mode[1:0] = 2'd2; Count[2:0] = 3'd3; Colour[0] = 1'b0;
    run(PERIOD * TDIV + 4);
    wait_phase(2);
    #1 RstN = 1'b0;
    #1;
    chk("arst_red", red, 1);
    chk("arst_green", green, 1);
    chk("arst_grant", Grant, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_tick", Tick, 0);
    Mode = 8'h00; Colour = 4'b0000; Count = '0;
    #1 RstN = 1'b1;
    model_reset();
    led_q.delete();
    led_q.push_back(2'b11);
    run(3 * PERIOD * TDIV + 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
